operand_skew_streamer: RTL and testbench
========================================

Name: operand_skew_streamer

Overview:
- Parametrised, runtime-dimensioned operand feeder for the systolic matrix multiplier. It replaces the fixed per-lane pushers.
- On a start handshake it latches MAX_DIM packed lane words for one operand side, A rows or B columns.
- It streams one DATA_WIDTH element per lane per cycle, with lane i delayed by i cycles, forming the diagonal wavefront the systolic array needs.
- It supports matrix dimension dim_i from 1 to MAX_DIM, per-lane valid, abort, a done pulse and a parameter error flag. The multiplier top instantiates two: west (A) and north (B).

Parameters:
- BUS_WIDTH, 32, width of one lane word (one row or column).
- DATA_WIDTH, 8, width of one element; BUS_WIDTH must be a multiple of it.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (derived localparam), number of lanes and elements per lane.
- CNT_W, $clog2(2*MAX_DIM) (derived localparam), width of the wavefront counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- data_i  in  MAX_DIM*BUS_WIDTH  packed lanes; lane i = bits [(i+1)*BUS_WIDTH-1 : i*BUS_WIDTH]; element k of a lane = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- dim_i  in  CNT_W  active dimension n; sampled only with start_i.
- start_i  in  1  start request.
- abort_i  in  1  cancel the current stream.
- ready_o  out  1  block can accept start_i this cycle.
- busy_o  out  1  stream in progress.
- data_o  out  MAX_DIM*DATA_WIDTH  per-lane element output; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- valid_o  out  MAX_DIM  per-lane element-valid.
- done_o  out  1  one-cycle pulse after the last element.
- err_o  out  1  one-cycle pulse when a start is rejected for a bad dim_i.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (rst_ni sampled on rising clk_i).
  - Reset values: state=IDLE, counter=0, data_o=0, valid_o=0, done_o=0, err_o=0, busy_o=0, ready_o=1.
  - All outputs are registered.
- States:
  - IDLE: ready_o=1, busy_o=0.
  - STREAM: ready_o=0, busy_o=1.
  - DONE: single cycle; done_o=1, ready_o=1, busy_o=0.
- Start acceptance: start_i && ready_o && 1<=dim_i<=MAX_DIM, at rising edge E.
  - data_i and dim_i are latched at E; counter t=0; next state STREAM.
  - The first outputs (t=0) are visible in the cycle after E.
- Invalid dim (0 or >MAX_DIM) with start_i && ready_o: err_o pulses the next cycle, the state does not change and nothing is latched.
- start_i while ready_o=0: ignored, no error.
- Streaming: at wavefront count t (0..2n-2), for each lane i:
  - If i<n and 0<=t-i<n: data_o lane i = latched element (t-i) of lane i, and valid_o[i]=1.
  - Otherwise: data_o lane i = 0 and valid_o[i]=0.
  - Lanes i>=n are always zero and invalid, whatever their data_i content.
- Stream length is exactly 2n-1 cycles. After t=2n-2 the next state is DONE; after DONE the next state is IDLE.
- Back-to-back: a valid start in the DONE cycle is accepted, and STREAM t=0 follows immediately with no idle gap.
- abort_i (when busy_o=1) has priority over counting.
  - Next cycle: state=IDLE, data_o=0, valid_o=0, no done_o.
  - abort_i in IDLE or DONE has no effect.
  - abort_i and start_i together in IDLE: start wins.
- Reset mid-stream: next cycle all outputs equal their reset values; latched data is discarded.
- Latched data is held unchanged during STREAM; data_i changes are ignored there.

Decomposition:
- Package matrix_stream_pkg holds:
  - the state enum (IDLE, STREAM, DONE);
  - a function max_dim(BUS_WIDTH, DATA_WIDTH);
  - a function cnt_w(max_dim).
- Sub-module skew_lane, one per lane via generate.
  - Each lane holds its MAX_DIM-element register bank, lane index LANE and the shared t/n.
  - It produces its own element and valid using the window lane<n && LANE<=t<LANE+n.
- The top holds the FSM, the counter, the dim check, err/done and abort.

Test Plan (BUS_WIDTH=32, DATA_WIDTH=8, MAX_DIM=4):
1. Reset held 2 cycles, then released -> ready_o=1; busy_o, done_o, err_o, valid_o, data_o all 0.
2. dim=4, lanes0..3 = 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, start -> over 7 cycles:
   - lane0 outputs 01,02,03,04 at t0..t3;
   - lane1 outputs 05..08 at t1..t4;
   - lane3 outputs 0D..10 at t3..t6;
   - valid_o = 0001, 0011, 0111, 1111, 1110, 1100, 1000;
   - done_o pulses at t7.
3. dim=2 with lanes2,3 = 0xFFFFFFFF -> 3 stream cycles:
   - lanes2,3 stay 0 with valid 0;
   - lane1 outputs 05,06 at t1,t2;
   - done_o pulses at t3.
4. start with dim=0, then with dim=5 -> err_o pulses once each, busy_o stays 0, no output activity.
5. dim=4 stream, abort_i at t=2 -> next cycle data_o=0, valid_o=0, ready_o=1, done_o never asserts. Repeat with rst_ni=0 at t=2 -> same reset values.
6. Second start (dim=3, new data) asserted during the DONE cycle -> accepted; its t=0 follows immediately, and the first stream's data never reappears.

Source files
------------

// File: rtl/matrix_stream_pkg.sv
// rtl/matrix_stream_pkg.sv - shared state type and size helpers for the operand streamers
package matrix_stream_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

   function automatic int max_dim(input int bus_width, input int data_width);
      return bus_width / data_width;
   endfunction

   // Counter must reach 2n-2 for n up to max_dim.
   function automatic int cnt_w(input int md);
      return (md < 1) ? 1 : $clog2(2 * md);
   endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - one lane: latched element bank and its skewed, windowed output register
module skew_lane
   import matrix_stream_pkg::*;
#(
   parameter  int BUS_WIDTH  = 32,
   parameter  int DATA_WIDTH = 8,
   parameter  int LANE       = 0,
   localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int CNT_W      = cnt_w(MAX_DIM)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic [BUS_WIDTH-1:0]  word_i,
   input  logic                  stream_i,
   input  logic [CNT_W-1:0]      t_i,
   input  logic [CNT_W-1:0]      n_i,
   output logic [DATA_WIDTH-1:0] elem_o,
   output logic                  valid_o
);

   localparam logic [CNT_W:0] LANE_C = (CNT_W + 1)'(LANE);

   logic [DATA_WIDTH-1:0] bank_q [MAX_DIM];
   logic [DATA_WIDTH-1:0] bank_d [MAX_DIM];
   logic [DATA_WIDTH-1:0] elem_q, elem_d;
   logic                  valid_q, valid_d;
   logic [CNT_W:0]        t_ext, n_ext;

   always_comb begin
      bank_d = bank_q;
      if (load_i) begin
         for (int k = 0; k < MAX_DIM; k++) begin
            bank_d[k] = word_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Output is registered from next-cycle t/n, so element k shows while t == LANE + k.
   always_comb begin
      t_ext   = {1'b0, t_i};
      n_ext   = {1'b0, n_i};
      elem_d  = '0;
      valid_d = 1'b0;
      if (stream_i && (LANE_C < n_ext)) begin
         for (int k = 0; k < MAX_DIM; k++) begin
            if (((CNT_W + 1)'(k) < n_ext) && (t_ext == LANE_C + (CNT_W + 1)'(k))) begin
               elem_d  = bank_d[k];
               valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < MAX_DIM; k++) begin
            bank_q[k] <= '0;
         end
         elem_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         bank_q  <= bank_d;
         elem_q  <= elem_d;
         valid_q <= valid_d;
      end
   end

   assign elem_o  = elem_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/operand_skew_streamer.sv
// rtl/operand_skew_streamer.sv - runtime-dimensioned diagonal wavefront feeder for one operand side
module operand_skew_streamer
   import matrix_stream_pkg::*;
#(
   parameter  int BUS_WIDTH  = 32,
   parameter  int DATA_WIDTH = 8,
   localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int CNT_W      = cnt_w(MAX_DIM)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [MAX_DIM*BUS_WIDTH-1:0]  data_i,
   input  logic [CNT_W-1:0]              dim_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   output logic                          ready_o,
   output logic                          busy_o,
   output logic [MAX_DIM*DATA_WIDTH-1:0] data_o,
   output logic [MAX_DIM-1:0]            valid_o,
   output logic                          done_o,
   output logic                          err_o
);

   localparam logic [CNT_W-1:0] MAX_DIM_C = CNT_W'(MAX_DIM);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] t_q, t_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             load, stream_d, dim_ok, start_ok, start_bad;
   logic [CNT_W:0]   last_t;

   assign dim_ok    = (dim_i != '0) && (dim_i <= MAX_DIM_C);
   assign start_ok  = start_i && ready_q && dim_ok;
   assign start_bad = start_i && ready_q && !dim_ok;
   assign last_t    = {n_q, 1'b0} - (CNT_W + 1)'(2);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         t_q     <= '0;
         n_q     <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         n_q     <= n_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // DONE accepts a start like IDLE so back-to-back streams have no gap.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      n_d     = n_q;
      load    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d = STREAM;
               t_d     = '0;
               n_d     = dim_i;
               load    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            if (abort_i) begin
               state_d = IDLE;
               t_d     = '0;
            end else if ({1'b0, t_q} == last_t) begin
               state_d = DONE;
               t_d     = '0;
            end else begin
               t_d = t_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   always_comb begin
      stream_d = (state_d == STREAM);
      ready_d  = (state_d != STREAM);
      busy_d   = (state_d == STREAM);
      done_d   = (state_d == DONE);
      err_d    = start_bad;
   end

   for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
      skew_lane #(
         .BUS_WIDTH  (BUS_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .LANE       (g)
      ) u_lane (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .load_i   (load),
         .word_i   (data_i[g*BUS_WIDTH +: BUS_WIDTH]),
         .stream_i (stream_d),
         .t_i      (t_d),
         .n_i      (n_d),
         .elem_o   (data_o[g*DATA_WIDTH +: DATA_WIDTH]),
         .valid_o  (valid_o[g])
      );
   end

   assign ready_o = ready_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_operand_skew_streamer.sv
// tb/tb_operand_skew_streamer.sv - scoreboard bench with a lane/time reference model
module tb_operand_skew_streamer;

   localparam int BW = 32;
   localparam int DW = 8;
   localparam int MD = 4;
   localparam int CW = 3;

   localparam int K_STREAM = 0;
   localparam int K_DONE   = 1;
   localparam int K_ERR    = 2;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic [MD*BW-1:0]  data_i;
   logic [CW-1:0]     dim_i;
   logic              start_i;
   logic              abort_i;
   logic              ready_o;
   logic              busy_o;
   logic [MD*DW-1:0]  data_o;
   logic [MD-1:0]     valid_o;
   logic              done_o;
   logic              err_o;

   always #5 clk = ~clk;

   operand_skew_streamer #(
      .BUS_WIDTH  (BW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .data_i  (data_i),
      .dim_i   (dim_i),
      .start_i (start_i),
      .abort_i (abort_i),
      .ready_o (ready_o),
      .busy_o  (busy_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .done_o  (done_o),
      .err_o   (err_o)
   );

   typedef struct {
      int               kind;
      logic [MD-1:0]    v;
      logic [MD*DW-1:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Reference: at wavefront time t, lane i carries element t-i of its word when that index lies in 0..n-1.
   task automatic push_stream(input int n, input logic [MD*BW-1:0] d, input int last_t);
      for (int t = 0; t <= last_t; t++) begin
         exp_t e;
         e.kind = K_STREAM;
         e.v    = '0;
         e.d    = '0;
         for (int i = 0; i < MD; i++) begin
            int k;
            k = t - i;
            if (i < n && k >= 0 && k < n) begin
               e.v[i]           = 1'b1;
               e.d[i*DW +: DW]  = d[i*BW + k*DW +: DW];
            end
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic push_kind(input int kind);
      exp_t e;
      e.kind = kind;
      e.v    = '0;
      e.d    = '0;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en && ((|valid_o) || done_o || err_o)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {valid_o, data_o, done_o, err_o}, 64'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("scoreboard",
                  {22'h0, valid_o, data_o, done_o, err_o, ready_o, busy_o},
                  {22'h0, e.v, e.d, e.kind == K_DONE, e.kind == K_ERR,
                   e.kind != K_STREAM, e.kind == K_STREAM});
         end
      end
   end

   function automatic logic [MD*BW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_check();
      @(posedge clk); #1;
      check("idle", {60'h0, ready_o, busy_o, |valid_o, done_o}, {60'h0, 4'b1000});
   endtask

   task automatic bad_start(input int dim);
      data_i  = rand_data();
      dim_i   = CW'(dim);
      start_i = 1'b1;
      push_kind(K_ERR);
      @(posedge clk); #1;
      start_i = 1'b0;
      check("err_no_busy", {62'h0, busy_o, ready_o}, {62'h0, 2'b01});
      @(posedge clk); #1;
      check("err_one_pulse", {63'h0, err_o}, 64'h0);
   endtask

   // cut_kind: 0 runs to DONE (returns in the DONE cycle), 1 aborts, 2 resets, both at cut_t.
   task automatic run_stream(input int n, input logic [MD*BW-1:0] d, input int cut_t, input int cut_kind);
      data_i  = d;
      dim_i   = CW'(n);
      start_i = 1'b1;
      abort_i = ($urandom_range(0, 3) == 0);
      if (cut_kind == 0) begin
         push_stream(n, d, 2*n - 2);
         push_kind(K_DONE);
      end else begin
         push_stream(n, d, cut_t);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      for (int c = 0; c < 2*n - 1; c++) begin
         if (cut_kind != 0 && c == cut_t) begin
            if (cut_kind == 1) abort_i = 1'b1;
            else               rst_ni  = 1'b0;
            @(posedge clk); #1;
            abort_i = 1'b0;
            rst_ni  = 1'b1;
            check(cut_kind == 1 ? "after_abort" : "after_reset",
                  {22'h0, valid_o, data_o, done_o, err_o, ready_o, busy_o},
                  {22'h0, 4'h0, 32'h0, 4'b0010});
            return;
         end
         data_i  = rand_data();
         dim_i   = CW'($urandom_range(0, 7));
         start_i = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         start_i = 1'b0;
      end
   endtask

   initial begin
      bit in_done;
      rst_ni  = 1'b0;
      data_i  = '0;
      dim_i   = '0;
      start_i = 1'b0;
      abort_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      check("rst_ready", {63'h0, ready_o}, 64'h1);
      check("rst_busy",  {63'h0, busy_o},  64'h0);
      check("rst_done",  {63'h0, done_o},  64'h0);
      check("rst_err",   {63'h0, err_o},   64'h0);
      check("rst_valid", {60'h0, valid_o}, 64'h0);
      check("rst_data",  {32'h0, data_o},  64'h0);
      mon_en = 1'b1;

      run_stream(4, {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, 0, 0);
      idle_check();
      run_stream(2, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h08070605, 32'h04030201}, 0, 0);
      idle_check();
      bad_start(0);
      bad_start(5);
      run_stream(4, rand_data(), 2, 1);
      idle_check();
      run_stream(4, rand_data(), 2, 2);
      idle_check();
      run_stream(4, {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, 0, 0);
      run_stream(3, {32'hDDDDDDDD, 32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0}, 0, 0);
      idle_check();

      in_done = 1'b0;
      for (int it = 0; it < 60; it++) begin
         int r;
         int n;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            int v;
            if (in_done) idle_check();
            in_done = 1'b0;
            v = $urandom_range(4, 7);
            bad_start(v == 4 ? 0 : v);
         end else begin
            n = $urandom_range(1, 4);
            if (in_done && $urandom_range(0, 1) == 0) idle_check();
            if (r == 1)      run_stream(n, rand_data(), $urandom_range(0, 2*n - 2), 1);
            else if (r == 2) run_stream(n, rand_data(), $urandom_range(0, 2*n - 2), 2);
            else             run_stream(n, rand_data(), 0, 0);
            in_done = (r > 2);
         end
      end
      if (in_done) idle_check();

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
